cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 8-bit CPU core.
- Drives instruction fetch, second-byte (immediate/address) fetch, execute, memory access and halt.
- Consumes the decoder's opcode and operand fields and produces all datapath strobes: PC, IR, register file, ALU flags, SP, memory request.
- Sits between the decoder, register file/ALU and the single shared memory port.

Parameters:
- SP_RESET, 8'hFF, stack-pointer value loaded by the SP register at reset; exported for benches only.
- HALT_ON_ILLEGAL, 1, 1 means an unknown opcode enters HALT with illegal=1; 0 means it executes as NOP.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  8  decoded opcode from the decoder (OP_* codes)
- operand2  in  3  instruction[2:0]; jump-condition field for JMP
- flag_z  in  1  ALU zero flag (registered)
- flag_c  in  1  ALU carry flag (registered)
- mem_ack  in  1  memory transfer completes at the rising edge where mem_req=1 and mem_ack=1
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read; valid when mem_req=1
- addr_sel  out  2  memory address source: 0 PC, 1 SP, 2 imm latch, 3 X (register operand2)
- wdata_sel  out  1  write-data source: 0 register oaddr, 1 PC (CALL)
- ir_we  out  1  load instruction register
- imm_we  out  1  load immediate/address latch
- pc_inc  out  1  PC <= PC+1 (mod 256)
- pc_load  out  1  PC load
- pc_src  out  1  0 imm latch, 1 memory read data
- reg_we  out  1  register-file write at iaddr
- reg_src  out  2  0 ALU, 1 imm, 2 register oaddr, 3 memory read data
- flags_we  out  1  latch ALU flags
- sp_inc  out  1  SP <= SP+1
- sp_dec  out  1  SP <= SP-1
- instr_done  out  1  one-cycle pulse on the last cycle of every instruction
- halted  out  1  high in HALT
- illegal  out  1  sticky; set on unknown opcode

Behaviour:
- Registered state; outputs are combinational from state, opcode and mem_ack.
- Reset: state=RST. All outputs 0; illegal=0. The first clock after rst_n deasserts goes to FETCH.
- Reset mid-instruction aborts immediately; no partial strobe is held.
- States: RST, FETCH, DECODE, OPERAND, EXEC, MEM, HALT.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. On ack: ir_we=1, pc_inc=1, then DECODE. Without ack, stay with outputs held stable.
- DECODE (1 cycle, no strobes):
  - LDI/JMP/CALL/LDA/STA go to OPERAND.
  - HLT goes to HALT.
  - NOP: instr_done=1, then FETCH.
  - Unknown opcode: if HALT_ON_ILLEGAL, set illegal and go to HALT; else behave as NOP.
  - All other opcodes go to EXEC.
- OPERAND: mem_req=1, addr_sel=0. On ack: imm_we=1, pc_inc=1, then EXEC.
- EXEC (1 cycle):
  - MOV: reg_we, reg_src=2.
  - LDI: reg_we, reg_src=1.
  - ALU: reg_we, reg_src=0, flags_we.
  - CMP: flags_we only.
  - For MOV/LDI/ALU/CMP: instr_done=1, then FETCH.
  - JMP: pc_load, pc_src=0 when the condition is true; instr_done=1; then FETCH.
  - PUSH/CALL: sp_dec=1, then MEM.
  - LDX/STX/LDA/STA/POP/RET: no strobe, then MEM.
- JMP conditions (operand2): 000 always, 001 Z, 010 !Z, 011 C, 100 !C, 101-111 never. A non-taken JMP is not an error.
- MEM: mem_req=1 until ack.
  - Address: LDX/STX addr_sel=3; LDA/STA addr_sel=2; PUSH/POP/CALL/RET addr_sel=1.
  - mem_we=1 for STX/STA/PUSH/CALL; wdata_sel=1 for CALL only.
  - On ack:
    - LDX/LDA/POP: reg_we, reg_src=3.
    - POP/RET: sp_inc.
    - RET: pc_load, pc_src=1.
    - CALL: pc_load, pc_src=0.
  - On ack: instr_done=1, then FETCH.
- Stack is full-descending: SP is pre-decremented on PUSH/CALL and post-incremented on POP/RET. SP and PC wrap mod 256 with no fault.
- HALT: all strobes 0, halted=1. Only reset leaves HALT.
- mem_ack asserted while mem_req=0 is ignored.
- Cycle count with mem_ack tied high:
  - NOP: 2 cycles.
  - MOV/ALU/CMP: 3 cycles.
  - LDI/JMP: 4 cycles.
  - PUSH/POP/LDX/STX/RET: 4 cycles.
  - LDA/STA/CALL: 5 cycles.

Optional Feature:
- Macro CPU_CTRL_SINGLE_STEP_EN.
- When defined: adds input step (1 bit) and state STEP_WAIT. Every transition to FETCH goes to STEP_WAIT instead. STEP_WAIT goes to FETCH on the cycle step=1. halted stays 0 in STEP_WAIT.
- When undefined: no step port and no STEP_WAIT; behaviour exactly as above.

Decomposition:
- symbols.vh gains CTRL_S_* state encodings, ADDR_SEL_*, REG_SRC_*, PC_SRC_*, and COND_* jump codes.
- Existing OP_* codes are reused unchanged.
- One sub-module: jump_cond (operand2, flag_z, flag_c -> take), purely combinational.

Test Plan:
- Reset held 3 cycles, release, mem_ack=1 -> all outputs 0 in RST; FETCH at cycle 1 with addr_sel=0, mem_req=1; ir_we+pc_inc on the same cycle.
- LDI r2,0x5A, ack=1 -> FETCH, DECODE, OPERAND(imm_we, pc_inc), EXEC(reg_we, reg_src=1), instr_done in cycle 4.
- JMP cond=001 with flag_z=0, then with flag_z=1 -> no pc_load, then pc_load with pc_src=0; instr_done both times.
- CALL 0x40, then RET, SP at 0xFF -> CALL: sp_dec in EXEC, MEM write addr_sel=1 with wdata_sel=1, pc_load imm. RET: read, sp_inc, pc_load with pc_src=1.
- LDX with mem_ack low 3 cycles -> mem_req and addr_sel=3 held stable 4 cycles; reg_we, reg_src=3 only on the ack cycle.
- HLT, and opcode 8'hEE with HALT_ON_ILLEGAL=1 -> halted=1, no strobes for 20 cycles; illegal=1 for 8'hEE only; rst_n low returns to RST.

Source files
------------

// File: rtl/cpu_ctrl_fsm_pkg.sv
// rtl/cpu_ctrl_fsm_pkg.sv - opcodes, state encodings, datapath select codes for the CPU control sequencer
package cpu_ctrl_fsm_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_MOV  = 8'h01;
  localparam logic [7:0] OP_LDI  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_AND  = 8'h05;
  localparam logic [7:0] OP_OR   = 8'h06;
  localparam logic [7:0] OP_XOR  = 8'h07;
  localparam logic [7:0] OP_CMP  = 8'h08;
  localparam logic [7:0] OP_JMP  = 8'h09;
  localparam logic [7:0] OP_PUSH = 8'h0A;
  localparam logic [7:0] OP_POP  = 8'h0B;
  localparam logic [7:0] OP_CALL = 8'h0C;
  localparam logic [7:0] OP_RET  = 8'h0D;
  localparam logic [7:0] OP_LDX  = 8'h0E;
  localparam logic [7:0] OP_STX  = 8'h0F;
  localparam logic [7:0] OP_LDA  = 8'h10;
  localparam logic [7:0] OP_STA  = 8'h11;
  localparam logic [7:0] OP_HLT  = 8'h12;

`ifdef CPU_CTRL_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    CTRL_S_RST, CTRL_S_FETCH, CTRL_S_DECODE, CTRL_S_OPERAND,
    CTRL_S_EXEC, CTRL_S_MEM, CTRL_S_HALT, CTRL_S_STEP_WAIT
  } ctrl_state_e;
`else
  typedef enum logic [2:0] {
    CTRL_S_RST, CTRL_S_FETCH, CTRL_S_DECODE, CTRL_S_OPERAND,
    CTRL_S_EXEC, CTRL_S_MEM, CTRL_S_HALT
  } ctrl_state_e;
`endif

  localparam logic [1:0] ADDR_SEL_PC  = 2'd0;
  localparam logic [1:0] ADDR_SEL_SP  = 2'd1;
  localparam logic [1:0] ADDR_SEL_IMM = 2'd2;
  localparam logic [1:0] ADDR_SEL_X   = 2'd3;

  localparam logic [1:0] REG_SRC_ALU = 2'd0;
  localparam logic [1:0] REG_SRC_IMM = 2'd1;
  localparam logic [1:0] REG_SRC_REG = 2'd2;
  localparam logic [1:0] REG_SRC_MEM = 2'd3;

  localparam logic PC_SRC_IMM = 1'b0;
  localparam logic PC_SRC_MEM = 1'b1;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_NC     = 3'b100;

  typedef enum logic [3:0] {
    OPC_NOP, OPC_MOV, OPC_LDI, OPC_ALU, OPC_CMP, OPC_JMP, OPC_PUSH, OPC_POP,
    OPC_CALL, OPC_RET, OPC_LDX, OPC_STX, OPC_LDA, OPC_STA, OPC_HLT, OPC_ILL
  } op_class_e;

  // Collapses the opcode space into the sequencing classes the FSM cares about.
  function automatic op_class_e op_classify(input logic [7:0] op);
    op_class_e cls;
    case (op)
      OP_NOP:  cls = OPC_NOP;
      OP_MOV:  cls = OPC_MOV;
      OP_LDI:  cls = OPC_LDI;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: cls = OPC_ALU;
      OP_CMP:  cls = OPC_CMP;
      OP_JMP:  cls = OPC_JMP;
      OP_PUSH: cls = OPC_PUSH;
      OP_POP:  cls = OPC_POP;
      OP_CALL: cls = OPC_CALL;
      OP_RET:  cls = OPC_RET;
      OP_LDX:  cls = OPC_LDX;
      OP_STX:  cls = OPC_STX;
      OP_LDA:  cls = OPC_LDA;
      OP_STA:  cls = OPC_STA;
      OP_HLT:  cls = OPC_HLT;
      default: cls = OPC_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_jump_cond.sv
// rtl/cpu_ctrl_fsm_jump_cond.sv - combinational JMP condition evaluation from operand2 and ALU flags
module cpu_ctrl_fsm_jump_cond
  import cpu_ctrl_fsm_pkg::*;
(
  input  logic [2:0] i_operand2,
  input  logic       i_flag_z,
  input  logic       i_flag_c,
  output logic       o_take
);

  always_comb begin
    o_take = 1'b0;
    case (i_operand2)
      COND_ALWAYS: o_take = 1'b1;
      COND_Z:      o_take = i_flag_z;
      COND_NZ:     o_take = ~i_flag_z;
      COND_C:      o_take = i_flag_c;
      COND_NC:     o_take = ~i_flag_c;
      default:     o_take = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle control sequencer for the 8-bit CPU core
// Optional single-step gate before every fetch: CPU_CTRL_SINGLE_STEP_EN.
module cpu_ctrl_fsm
  import cpu_ctrl_fsm_pkg::*;
#(
  parameter logic [7:0] SP_RESET        = 8'hFF,
  parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic       step,
`endif
  input  logic [7:0] opcode,
  input  logic [2:0] operand2,
  input  logic       flag_z,
  input  logic       flag_c,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] addr_sel,
  output logic       wdata_sel,
  output logic       ir_we,
  output logic       imm_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       pc_src,
  output logic       reg_we,
  output logic [1:0] reg_src,
  output logic       flags_we,
  output logic       sp_inc,
  output logic       sp_dec,
  output logic       instr_done,
  output logic       halted,
  output logic       illegal
);

`ifdef CPU_CTRL_SINGLE_STEP_EN
  localparam ctrl_state_e S_FETCH_ENTRY = CTRL_S_STEP_WAIT;
`else
  localparam ctrl_state_e S_FETCH_ENTRY = CTRL_S_FETCH;
`endif

  ctrl_state_e r_state;
  ctrl_state_e w_state_nxt;
  logic        r_illegal;
  logic        w_set_illegal;
  op_class_e   w_class;
  logic        w_take;
  logic [7:0]  w_unused_sp_reset;

  // SP_RESET belongs to the SP register; kept here so benches see one parameter set.
  assign w_unused_sp_reset = SP_RESET;
  assign w_class = op_classify(opcode);
  assign illegal = r_illegal;

  cpu_ctrl_fsm_jump_cond u_jump_cond (
    .i_operand2 (operand2),
    .i_flag_z   (flag_z),
    .i_flag_c   (flag_c),
    .o_take     (w_take)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CTRL_S_RST;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_set_illegal = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    addr_sel      = ADDR_SEL_PC;
    wdata_sel     = 1'b0;
    ir_we         = 1'b0;
    imm_we        = 1'b0;
    pc_inc        = 1'b0;
    pc_load       = 1'b0;
    pc_src        = PC_SRC_IMM;
    reg_we        = 1'b0;
    reg_src       = REG_SRC_ALU;
    flags_we      = 1'b0;
    sp_inc        = 1'b0;
    sp_dec        = 1'b0;
    instr_done    = 1'b0;
    halted        = 1'b0;

    case (r_state)
      CTRL_S_RST: w_state_nxt = S_FETCH_ENTRY;

      CTRL_S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_we       = 1'b1;
          pc_inc      = 1'b1;
          w_state_nxt = CTRL_S_DECODE;
        end
      end

      CTRL_S_DECODE: begin
        case (w_class)
          OPC_LDI, OPC_JMP, OPC_CALL, OPC_LDA, OPC_STA: w_state_nxt = CTRL_S_OPERAND;
          OPC_HLT: w_state_nxt = CTRL_S_HALT;
          OPC_NOP: begin
            instr_done  = 1'b1;
            w_state_nxt = S_FETCH_ENTRY;
          end
          OPC_ILL: begin
            if (HALT_ON_ILLEGAL) begin
              w_set_illegal = 1'b1;
              w_state_nxt   = CTRL_S_HALT;
            end else begin
              instr_done  = 1'b1;
              w_state_nxt = S_FETCH_ENTRY;
            end
          end
          default: w_state_nxt = CTRL_S_EXEC;
        endcase
      end

      CTRL_S_OPERAND: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          imm_we      = 1'b1;
          pc_inc      = 1'b1;
          w_state_nxt = CTRL_S_EXEC;
        end
      end

      CTRL_S_EXEC: begin
        case (w_class)
          OPC_MOV: begin
            reg_we  = 1'b1;
            reg_src = REG_SRC_REG;
          end
          OPC_LDI: begin
            reg_we  = 1'b1;
            reg_src = REG_SRC_IMM;
          end
          OPC_ALU: begin
            reg_we   = 1'b1;
            reg_src  = REG_SRC_ALU;
            flags_we = 1'b1;
          end
          OPC_CMP: flags_we = 1'b1;
          OPC_JMP: begin
            pc_load = w_take;
            pc_src  = PC_SRC_IMM;
          end
          OPC_PUSH, OPC_CALL: sp_dec = 1'b1;
          default: ;
        endcase
        // Stack and memory-operand classes finish in MEM; everything else retires here.
        case (w_class)
          OPC_PUSH, OPC_CALL, OPC_POP, OPC_RET,
          OPC_LDX, OPC_STX, OPC_LDA, OPC_STA: w_state_nxt = CTRL_S_MEM;
          default: begin
            instr_done  = 1'b1;
            w_state_nxt = S_FETCH_ENTRY;
          end
        endcase
      end

      CTRL_S_MEM: begin
        mem_req = 1'b1;
        case (w_class)
          OPC_LDX, OPC_STX: addr_sel = ADDR_SEL_X;
          OPC_LDA, OPC_STA: addr_sel = ADDR_SEL_IMM;
          default:          addr_sel = ADDR_SEL_SP;
        endcase
        mem_we    = (w_class == OPC_STX) || (w_class == OPC_STA) ||
                    (w_class == OPC_PUSH) || (w_class == OPC_CALL);
        wdata_sel = (w_class == OPC_CALL);
        if (mem_ack) begin
          case (w_class)
            OPC_LDX, OPC_LDA: begin
              reg_we  = 1'b1;
              reg_src = REG_SRC_MEM;
            end
            OPC_POP: begin
              reg_we  = 1'b1;
              reg_src = REG_SRC_MEM;
              sp_inc  = 1'b1;
            end
            OPC_RET: begin
              sp_inc  = 1'b1;
              pc_load = 1'b1;
              pc_src  = PC_SRC_MEM;
            end
            OPC_CALL: begin
              pc_load = 1'b1;
              pc_src  = PC_SRC_IMM;
            end
            default: ;
          endcase
          instr_done  = 1'b1;
          w_state_nxt = S_FETCH_ENTRY;
        end
      end

      CTRL_S_HALT: halted = 1'b1;

`ifdef CPU_CTRL_SINGLE_STEP_EN
      CTRL_S_STEP_WAIT: begin
        if (step) w_state_nxt = CTRL_S_FETCH;
      end
`endif

      default: w_state_nxt = CTRL_S_RST;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - randomized self-checking bench for cpu_ctrl_fsm against an instruction-phase model
module tb_cpu_ctrl_fsm;
  import cpu_ctrl_fsm_pkg::*;

  typedef enum int {
    K_NOP, K_MOV, K_LDI, K_ALU, K_CMP, K_JMP, K_PUSH, K_POP,
    K_CALL, K_RET, K_LDX, K_STX, K_LDA, K_STA, K_HLT, K_ILL
  } kind_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] addr_sel;
    logic       wdata_sel;
    logic       ir_we;
    logic       imm_we;
    logic       pc_inc;
    logic       pc_load;
    logic       pc_src;
    logic       reg_we;
    logic [1:0] reg_src;
    logic       flags_we;
    logic       sp_inc;
    logic       sp_dec;
    logic       instr_done;
    logic       halted;
    logic       illegal;
  } outs_t;

  // One phase of an instruction: optional ack wait, outputs while waiting, outputs on the final cycle.
  typedef struct {
    bit    waits;
    outs_t hold;
    outs_t done;
  } step_t;

  logic       clk;
  logic       rst_n;
  logic       step;
  logic [7:0] opcode;
  logic [2:0] operand2;
  logic       flag_z, flag_c, mem_ack;
  logic       mem_req, mem_we, wdata_sel, ir_we, imm_we, pc_inc, pc_load, pc_src;
  logic       reg_we, flags_we, sp_inc, sp_dec, instr_done, halted, illegal;
  logic [1:0] addr_sel, reg_src;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  step_t steps[$];

  cpu_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step       (step),
`endif
    .opcode     (opcode),
    .operand2   (operand2),
    .flag_z     (flag_z),
    .flag_c     (flag_c),
    .mem_ack    (mem_ack),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_sel   (addr_sel),
    .wdata_sel  (wdata_sel),
    .ir_we      (ir_we),
    .imm_we     (imm_we),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_src     (pc_src),
    .reg_we     (reg_we),
    .reg_src    (reg_src),
    .flags_we   (flags_we),
    .sp_inc     (sp_inc),
    .sp_dec     (sp_dec),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%05h expected 0x%05h", tag, got, exp);
  endtask

  function automatic outs_t observe();
    outs_t o;
    o.mem_req = mem_req;   o.mem_we = mem_we;       o.addr_sel = addr_sel;
    o.wdata_sel = wdata_sel; o.ir_we = ir_we;       o.imm_we = imm_we;
    o.pc_inc = pc_inc;     o.pc_load = pc_load;     o.pc_src = pc_src;
    o.reg_we = reg_we;     o.reg_src = reg_src;     o.flags_we = flags_we;
    o.sp_inc = sp_inc;     o.sp_dec = sp_dec;       o.instr_done = instr_done;
    o.halted = halted;     o.illegal = illegal;
    return o;
  endfunction

  // Inputs are driven just after a rising edge; outputs are compared on the falling edge.
  task automatic tick_check(input string tag, input outs_t exp);
    @(negedge clk);
    chk_eq(tag, 32'(observe()), 32'(exp));
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] op_of(input kind_e k);
    case (k)
      K_NOP:  return OP_NOP;
      K_MOV:  return OP_MOV;
      K_LDI:  return OP_LDI;
      K_ALU:  return OP_ADD + 8'($urandom_range(4, 0));
      K_CMP:  return OP_CMP;
      K_JMP:  return OP_JMP;
      K_PUSH: return OP_PUSH;
      K_POP:  return OP_POP;
      K_CALL: return OP_CALL;
      K_RET:  return OP_RET;
      K_LDX:  return OP_LDX;
      K_STX:  return OP_STX;
      K_LDA:  return OP_LDA;
      K_STA:  return OP_STA;
      K_HLT:  return OP_HLT;
      default: return 8'hEE;
    endcase
  endfunction

  function automatic bit spec_take(input logic [2:0] c, input logic z, input logic cy);
    case (c)
      3'd0: return 1'b1;
      3'd1: return z;
      3'd2: return !z;
      3'd3: return cy;
      3'd4: return !cy;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int spec_cycles(input kind_e k);
    case (k)
      K_NOP: return 2;
      K_MOV, K_ALU, K_CMP: return 3;
      K_LDI, K_JMP, K_PUSH, K_POP, K_LDX, K_STX, K_RET: return 4;
      K_LDA, K_STA, K_CALL: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic void build_steps(input kind_e k, input bit take);
    outs_t z = '0;
    step_t s;
    bit two_byte = k inside {K_LDI, K_JMP, K_CALL, K_LDA, K_STA};
    bit uses_mem = k inside {K_PUSH, K_POP, K_CALL, K_RET, K_LDX, K_STX, K_LDA, K_STA};
    steps.delete();
    s.waits = 1'b1; s.hold = z; s.hold.mem_req = 1'b1;
    s.done = s.hold; s.done.ir_we = 1'b1; s.done.pc_inc = 1'b1;
    steps.push_back(s);
    s.waits = 1'b0; s.hold = z; s.done = z;
    steps.push_back(s);
    if (two_byte) begin
      s.waits = 1'b1; s.hold = z; s.hold.mem_req = 1'b1;
      s.done = s.hold; s.done.imm_we = 1'b1; s.done.pc_inc = 1'b1;
      steps.push_back(s);
    end
    if (!(k inside {K_NOP, K_HLT, K_ILL})) begin
      s.waits = 1'b0; s.hold = z; s.done = z;
      case (k)
        K_MOV: begin s.done.reg_we = 1'b1; s.done.reg_src = 2'd2; end
        K_LDI: begin s.done.reg_we = 1'b1; s.done.reg_src = 2'd1; end
        K_ALU: begin s.done.reg_we = 1'b1; s.done.reg_src = 2'd0; s.done.flags_we = 1'b1; end
        K_CMP: s.done.flags_we = 1'b1;
        K_JMP: s.done.pc_load = take;
        K_PUSH, K_CALL: s.done.sp_dec = 1'b1;
        default: ;
      endcase
      steps.push_back(s);
    end
    if (uses_mem) begin
      s.waits = 1'b1; s.hold = z; s.hold.mem_req = 1'b1;
      s.hold.addr_sel = (k inside {K_LDX, K_STX}) ? 2'd3 : (k inside {K_LDA, K_STA}) ? 2'd2 : 2'd1;
      s.hold.mem_we = k inside {K_STX, K_STA, K_PUSH, K_CALL};
      s.hold.wdata_sel = (k == K_CALL);
      s.done = s.hold;
      if (k inside {K_LDX, K_LDA, K_POP}) begin s.done.reg_we = 1'b1; s.done.reg_src = 2'd3; end
      if (k inside {K_POP, K_RET}) s.done.sp_inc = 1'b1;
      if (k == K_RET)  begin s.done.pc_load = 1'b1; s.done.pc_src = 1'b1; end
      if (k == K_CALL) begin s.done.pc_load = 1'b1; s.done.pc_src = 1'b0; end
      steps.push_back(s);
    end
    if (!(k inside {K_HLT, K_ILL})) steps[steps.size()-1].done.instr_done = 1'b1;
  endfunction

  task automatic run_instr(input kind_e k, input logic [2:0] o2, input logic z, input logic c,
                           input int wlo, input int whi);
    int    start, nwait, waits;
    outs_t e;
    logic [7:0] op;
    op = op_of(k);
    build_steps(k, spec_take(o2, z, c));
    start = cyc;
    waits = 0;
    for (int i = 0; i < steps.size(); i++) begin
      if (i == 1) begin opcode = op; operand2 = o2; flag_z = z; flag_c = c; end
      nwait = steps[i].waits ? int'($urandom_range(whi, wlo)) : 0;
      for (int w = 0; w < nwait; w++) begin
        mem_ack = 1'b0;
        tick_check($sformatf("%s s%0d wait", k.name(), i), steps[i].hold);
      end
      waits += nwait;
      mem_ack = steps[i].waits ? 1'b1 : 1'($urandom_range(1, 0));
      tick_check($sformatf("%s s%0d", k.name(), i), steps[i].done);
    end
    if (k inside {K_HLT, K_ILL}) begin
      e = '0; e.halted = 1'b1; e.illegal = (k == K_ILL);
      for (int h = 0; h < 20; h++) begin
        mem_ack = 1'($urandom_range(1, 0));
        tick_check($sformatf("%s halt", k.name()), e);
      end
    end else begin
      chk_eq($sformatf("%s cycles", k.name()), 32'(cyc - start - waits), 32'(spec_cycles(k)));
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    mem_ack = 1'b1;
    for (int i = 0; i < n; i++) tick_check("reset", '0);
    rst_n = 1'b1;
    tick_check("rst_release", '0);
  endtask

  initial begin
    outs_t e;
    kind_e k;
    rst_n = 1'b1; step = 1'b1; opcode = 8'h00; operand2 = 3'd0;
    flag_z = 1'b0; flag_c = 1'b0; mem_ack = 1'b1;
    #1;
    do_reset(3);

    run_instr(K_LDI, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(K_JMP, 3'd1, 1'b0, 1'b0, 0, 0);
    run_instr(K_JMP, 3'd1, 1'b1, 1'b0, 0, 0);
    run_instr(K_CALL, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(K_RET, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(K_LDX, 3'd5, 1'b0, 1'b0, 3, 3);

    for (int n = 0; n < 80; n++) begin
      k = kind_e'($urandom_range(int'(K_STA), int'(K_NOP)));
      run_instr(k, 3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)),
                1'($urandom_range(1, 0)), 0, 3);
    end

    // Stalled fetch, then reset in the middle of it.
    mem_ack = 1'b0;
    e = '0; e.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) tick_check("fetch_stall", e);
    rst_n = 1'b0;
    tick_check("abort", '0);
    do_reset(2);

    run_instr(K_HLT, 3'd0, 1'b0, 1'b0, 0, 0);
    rst_n = 1'b0;
    tick_check("halt_reset", '0);
    do_reset(2);
    run_instr(K_NOP, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(K_ILL, 3'd0, 1'b0, 1'b0, 0, 2);
    rst_n = 1'b0;
    tick_check("ill_reset", '0);
    do_reset(2);
    run_instr(K_MOV, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(K_STA, 3'd0, 1'b0, 1'b0, 1, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
